// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the seven-segment display path: glyph codes,
//   active-low segment patterns ({g,f,e,d,c,b,a}), display geometry and
//   the scan-driver state encoding. Imported by the scan driver, the glyph
//   decoder, the operation dispatcher and the greetings/stopwatch producers.
package seg7_pkg;

   localparam int DIGITS = 8;
   localparam int CODE_W = 5;
   localparam int SEG_W  = 7;
   localparam int IDX_W  = 3;

   // Glyph codes beyond the 0x00-0x0F hex range
   localparam logic [CODE_W-1:0] G_H          = 5'h10;
   localparam logic [CODE_W-1:0] G_I          = 5'h11;
   localparam logic [CODE_W-1:0] G_L          = 5'h12;
   localparam logic [CODE_W-1:0] G_P          = 5'h13;
   localparam logic [CODE_W-1:0] G_R          = 5'h14;
   localparam logic [CODE_W-1:0] G_N          = 5'h15;
   localparam logic [CODE_W-1:0] G_O          = 5'h16;
   localparam logic [CODE_W-1:0] G_U          = 5'h17;
   localparam logic [CODE_W-1:0] G_MINUS      = 5'h18;
   localparam logic [CODE_W-1:0] G_UNDERSCORE = 5'h19;
   localparam logic [CODE_W-1:0] G_BLANK      = 5'h1F;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0          = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1          = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2          = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3          = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4          = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5          = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6          = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7          = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8          = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9          = 7'h10;
   localparam logic [SEG_W-1:0] SEG_A          = 7'h08;
   localparam logic [SEG_W-1:0] SEG_B          = 7'h03;
   localparam logic [SEG_W-1:0] SEG_C          = 7'h46;
   localparam logic [SEG_W-1:0] SEG_D          = 7'h21;
   localparam logic [SEG_W-1:0] SEG_E          = 7'h06;
   localparam logic [SEG_W-1:0] SEG_F          = 7'h0E;
   localparam logic [SEG_W-1:0] SEG_H          = 7'h09;
   localparam logic [SEG_W-1:0] SEG_I          = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_L          = 7'h47;
   localparam logic [SEG_W-1:0] SEG_P          = 7'h0C;
   localparam logic [SEG_W-1:0] SEG_R          = 7'h2F;
   localparam logic [SEG_W-1:0] SEG_N          = 7'h2B;
   localparam logic [SEG_W-1:0] SEG_O          = 7'h23;
   localparam logic [SEG_W-1:0] SEG_U          = 7'h41;
   localparam logic [SEG_W-1:0] SEG_MINUS      = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_UNDERSCORE = 7'h77;
   localparam logic [SEG_W-1:0] SEG_BLANK      = 7'h7F;

   localparam logic [DIGITS-1:0] AN_OFF = 8'hFF;

   // Scan phase of the current counter position
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode
//   Purely combinational glyph-code to segment-pattern translation.
//   Ports:
//     code  in  5  glyph code (see seg7_pkg)
//     seg   out 7  active-low {g,f,e,d,c,b,a}; reserved codes render blank
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [SEG_W-1:0]  seg
);

   // Look up the segment pattern for the requested glyph
   always_comb begin
      seg = SEG_BLANK;
      case (code)
         5'h00:        seg = SEG_0;
         5'h01:        seg = SEG_1;
         5'h02:        seg = SEG_2;
         5'h03:        seg = SEG_3;
         5'h04:        seg = SEG_4;
         5'h05:        seg = SEG_5;
         5'h06:        seg = SEG_6;
         5'h07:        seg = SEG_7;
         5'h08:        seg = SEG_8;
         5'h09:        seg = SEG_9;
         5'h0A:        seg = SEG_A;
         5'h0B:        seg = SEG_B;
         5'h0C:        seg = SEG_C;
         5'h0D:        seg = SEG_D;
         5'h0E:        seg = SEG_E;
         5'h0F:        seg = SEG_F;
         G_H:          seg = SEG_H;
         G_I:          seg = SEG_I;
         G_L:          seg = SEG_L;
         G_P:          seg = SEG_P;
         G_R:          seg = SEG_R;
         G_N:          seg = SEG_N;
         G_O:          seg = SEG_O;
         G_U:          seg = SEG_U;
         G_MINUS:      seg = SEG_MINUS;
         G_UNDERSCORE: seg = SEG_UNDERSCORE;
         default:      seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes eight glyph codes onto a common-anode 8-digit display.
//   The display word is captured once per frame (at the start of digit 0's
//   slot) so a frame never mixes old and new digits, and every slot opens
//   with a blanking interval to suppress ghosting between digits.
//   Ports:
//     clk         in  1   system clock
//     reset       in  1   asynchronous active-low reset
//     enable      in  1   1 = scan, 0 = display dark
//     display     in  40  glyph codes, [39:35] leftmost (an[7]) .. [4:0] rightmost (an[0])
//     dp_mask     in  8   bit i lights decimal point of digit i
//     an          out 8   anode enables, active-low
//     seg         out 7   segments {g,f,e,d,c,b,a}, active-low
//     dp          out 1   decimal point, active-low
//     frame_tick  out 1   one-cycle pulse after each snapshot
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [DIGITS*CODE_W-1:0] display,
   input  logic [DIGITS-1:0]        dp_mask,
   output logic [DIGITS-1:0]        an,
   output logic [SEG_W-1:0]         seg,
   output logic                     dp,
   output logic                     frame_tick
);

   localparam int               CNT_W     = $clog2(DIGIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

   scan_state_t         state_r, state_n_s;
   logic [CNT_W-1:0]    cnt_r, cnt_n_s;
   logic [IDX_W-1:0]    idx_r, idx_n_s;
   logic [CODE_W-1:0]   shadow_r [DIGITS];
   logic [DIGITS-1:0]   shadow_dp_r;
   logic                snap_s;
   logic [SEG_W-1:0]    glyph_seg_s;
   logic [DIGITS-1:0]   an_r, an_n_s;
   logic [SEG_W-1:0]    seg_r, seg_n_s;
   logic                dp_r, dp_n_s;
   logic                frame_tick_r;

   seg7_glyph_decode u_decode (
      .code (shadow_r[idx_r]),
      .seg  (glyph_seg_s)
   );

   // Next counter position, snapshot request and next pin values
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      idx_n_s   = idx_r;
      snap_s    = 1'b0;
      an_n_s    = AN_OFF;
      seg_n_s   = SEG_BLANK;
      dp_n_s    = 1'b1;
      if (!enable) begin
         // Disabling takes priority over a coincident slot wrap
         state_n_s = ST_IDLE;
         cnt_n_s   = CNT_ZERO;
         idx_n_s   = IDX_ZERO;
      end else begin
         snap_s = (cnt_r == CNT_ZERO) && (idx_r == IDX_ZERO);
         if (cnt_r == CNT_LAST) begin
            cnt_n_s = CNT_ZERO;
            idx_n_s = idx_r + IDX_ONE;   // 7 wraps to 0 naturally
         end else begin
            cnt_n_s = cnt_r + CNT_ONE;
            idx_n_s = idx_r;
         end
         state_n_s = (cnt_n_s < BLANK_LIM) ? ST_BLANK : ST_DRIVE;
         // IDLE sits at cnt 0, so it renders exactly like BLANK here
         case (state_r)
            ST_DRIVE: begin
               an_n_s  = ~(8'd1 << idx_r);
               seg_n_s = glyph_seg_s;
               dp_n_s  = ~shadow_dp_r[idx_r];
            end
            default: begin
               an_n_s  = AN_OFF;
               seg_n_s = SEG_BLANK;
               dp_n_s  = 1'b1;
            end
         endcase
      end
   end

   // Counter/state register and registered pin outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= CNT_ZERO;
         idx_r        <= IDX_ZERO;
         an_r         <= AN_OFF;
         seg_r        <= SEG_BLANK;
         dp_r         <= 1'b1;
         frame_tick_r <= 1'b0;
      end else begin
         state_r      <= state_n_s;
         cnt_r        <= cnt_n_s;
         idx_r        <= idx_n_s;
         an_r         <= an_n_s;
         seg_r        <= seg_n_s;
         dp_r         <= dp_n_s;
         frame_tick_r <= snap_s;
      end
   end

   // Frame shadow of the display word and decimal-point mask
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DIGITS; i++) begin
            shadow_r[i] <= G_BLANK;
         end
         shadow_dp_r <= {DIGITS{1'b0}};
      end else if (snap_s) begin
         for (int i = 0; i < DIGITS; i++) begin
            shadow_r[i] <= display[i*CODE_W +: CODE_W];
         end
         shadow_dp_r <= dp_mask;
      end else begin
         shadow_dp_r <= shadow_dp_r;
      end
   end

   assign an         = an_r;
   assign seg        = seg_r;
   assign dp         = dp_r;
   assign frame_tick = frame_tick_r;

endmodule
